cam_pixel_capture: RTL and testbench
====================================

CAM_PIXEL_CAPTURE -- requirements
Module: cam_pixel_capture

Interface
REQ-001 Parameter AW, default 15: address width of the frame buffer write port.
REQ-002 Parameter DW, default 12: pixel width, RGB444 {R[3:0],G[3:0],B[3:0]}.
REQ-003 Parameter IMG_W, default 160: pixels per line.
REQ-004 Parameter IMG_H, default 120: lines per frame; IMG_W*IMG_H is the pixel count NPIX (19200).
REQ-005 pclk  in  1: camera pixel clock, the only clock; also drives the frame buffer write clock clk_w.
REQ-006 rst  in  1: one clock; reset is synchronous and active-low.
REQ-007 en  in  1: capture enable, sampled only at start of frame.
REQ-008 vsync  in  1: camera frame sync, high between frames.
REQ-009 href  in  1: camera line valid, high while pixel bytes are valid.
REQ-010 px_data  in  8: camera byte bus (RGB444, two bytes per pixel).
REQ-011 addr_in  out  AW: frame buffer write address.
REQ-012 data_in  out  DW: frame buffer write data.
REQ-013 regwrite  out  1: frame buffer write strobe, one pclk per pixel.
REQ-014 frame_done  out  1: one-cycle pulse at end of a captured frame.
REQ-015 frame_err  out  1: sticky, set when a captured frame's pixel count differs from NPIX.

Function
REQ-016 All inputs are sampled on rising pclk; vsync is delayed one cycle internally for edge detection.
REQ-017 FSM states: IDLE, WAIT_SOF, BYTE1, BYTE2.
REQ-018 IDLE: en=1 and vsync=1 -> WAIT_SOF; otherwise stay.
REQ-019 WAIT_SOF: vsync falling edge -> BYTE1 with pixel address cleared to 0.
REQ-020 BYTE1: href=1 -> latch px_data[3:0] as R and go to BYTE2; href=0 -> stay, no write.
REQ-021 BYTE2: href=1 -> latch px_data[7:4] as G and px_data[3:0] as B, then go to BYTE1.
REQ-022 In BYTE2 with href=0 (line ended on odd byte), the half pixel is discarded, there is no write, and the state returns to BYTE1.
REQ-023 regwrite pulses high the cycle after the BYTE2 sample, with data_in={R,G,B} and addr_in=current address held valid for that cycle.
REQ-024 The address increments by 1 after each write; writes are suppressed once the address reaches NPIX, so address NPIX (the reserved black pixel) and above are never written.
REQ-025 vsync rising edge in BYTE1/BYTE2 ends the frame: frame_done pulses for 1 cycle, and frame_err is set if the write count is not NPIX.
REQ-026 After frame end: en=1 -> WAIT_SOF; en=0 -> IDLE.
REQ-027 Deasserting en mid-frame has no effect until frame end.
REQ-028 A write pending from BYTE2 completes even when vsync rises in the same cycle; the count check includes it.
REQ-029 The write counter is AW bits wide and saturates at NPIX without wrapping.

Reset
REQ-030 When rst=0 at a pclk edge, state becomes IDLE and addr_in=0, data_in=0, regwrite=0, frame_done=0, frame_err=0, and the counter and latches clear.
REQ-031 Reset mid-frame aborts the frame with no frame_done; capture resumes only from the next complete vsync high-to-low sequence.

Structure
REQ-032 The shared package holds the state encoding, the default IMG_W, IMG_H, AW and DW, and NPIX.
REQ-033 The block is single-level with no sub-module; the vsync edge detector is inline.

Verification
REQ-034 Full frame, en=1, 120 lines of 320 bytes with bytes 0x0A,0xBC -> 19200 regwrite pulses, data_in=12'hABC, addresses 0..19199 in order, one frame_done, frame_err=0.
REQ-035 en=0 during vsync -> no regwrite or frame_done for that frame; en=1 before the next vsync -> the next frame is captured.
REQ-036 Short frame of 100 lines -> 16000 writes, frame_done pulses, frame_err=1 and stays 1 through the next good frame.
REQ-037 Long frame of 130 lines -> writes stop after address 19199, address 19200 is never written, frame_err=1.
REQ-038 Line of 321 bytes (odd) -> 160 writes only; the next line starts at the BYTE1 alignment.
REQ-039 rst=0 asserted at pixel 5000 -> all outputs are 0 the next cycle; the frame in progress produces no writes; the following frame starts at address 0.

Source files
------------

// File: rtl/cam_pixel_capture_pkg.sv
// Shared definitions for the camera pixel capture block: default frame geometry,
// bus widths and the capture FSM state encoding.
package cam_pixel_capture_pkg;

  localparam int CPC_AW    = 15;
  localparam int CPC_DW    = 12;
  localparam int CPC_IMG_W = 160;
  localparam int CPC_IMG_H = 120;
  localparam int CPC_NPIX  = CPC_IMG_W * CPC_IMG_H;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_SOF = 2'd1,
    ST_BYTE1    = 2'd2,
    ST_BYTE2    = 2'd3
  } state_t;

endpackage

// File: rtl/cam_pixel_capture_if.sv
// Camera-side inputs and frame-buffer write-port outputs of the pixel capture block.
// The slave modport is the capture block; the master modport is whoever drives the camera bus.
interface cam_pixel_capture_if
  import cam_pixel_capture_pkg::*;
#(
  parameter int AW = CPC_AW,
  parameter int DW = CPC_DW
) ();

  logic          en;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;
  logic          frame_err;

  modport master (
    output en, vsync, href, px_data,
    input  addr_in, data_in, regwrite, frame_done, frame_err
  );

  modport slave (
    input  en, vsync, href, px_data,
    output addr_in, data_in, regwrite, frame_done, frame_err
  );

endinterface

// File: rtl/cam_pixel_capture.sv
// Captures RGB444 pixels (two bytes each) from a camera bus into frame-buffer writes,
// one write per pixel, and flags frames whose pixel count is not exactly IMG_W*IMG_H.
module cam_pixel_capture
  import cam_pixel_capture_pkg::*;
#(
  parameter int AW    = CPC_AW,
  parameter int DW    = CPC_DW,
  parameter int IMG_W = CPC_IMG_W,
  parameter int IMG_H = CPC_IMG_H
) (
  input  logic pclk,
  input  logic rst,
  cam_pixel_capture_if.slave bus
);

  localparam int            NPIX   = IMG_W * IMG_H;
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);

  state_t        state_q, state_d;
  logic          vsync_q, vsync_d;
  logic [3:0]    r_q, r_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] addr_in_q, addr_in_d;
  logic [DW-1:0] data_in_q, data_in_d;
  logic          regwrite_q, regwrite_d;
  logic          frame_done_q, frame_done_d;
  logic          frame_err_q, frame_err_d;

  logic vs_rise, vs_fall, end_frame;

  assign vs_rise = bus.vsync & ~vsync_q;
  assign vs_fall = ~bus.vsync & vsync_q;

  always_comb begin
    state_d      = state_q;
    vsync_d      = bus.vsync;
    r_d          = r_q;
    ptr_d        = ptr_q;
    ovf_d        = ovf_q;
    addr_in_d    = addr_in_q;
    data_in_d    = data_in_q;
    regwrite_d   = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = frame_err_q;
    end_frame    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.en && bus.vsync) state_d = ST_WAIT_SOF;
      end
      ST_WAIT_SOF: begin
        if (vs_fall) begin
          state_d = ST_BYTE1;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_BYTE1: begin
        if (vs_rise) begin
          end_frame = 1'b1;
        end else if (bus.href) begin
          r_d     = bus.px_data[3:0];
          state_d = ST_BYTE2;
        end
      end
      ST_BYTE2: begin
        // Odd-length lines land here with href low: the half pixel is simply dropped.
        if (bus.href) begin
          if (ptr_q < NPIX_A) begin
            regwrite_d = 1'b1;
            addr_in_d  = ptr_q;
            data_in_d  = DW'({r_q, bus.px_data});
            ptr_d      = ptr_q + AW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        state_d = ST_BYTE1;
        if (vs_rise) end_frame = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Count check uses the post-update counter so a write issued this cycle is included.
    if (end_frame) begin
      frame_done_d = 1'b1;
      if ((ptr_d != NPIX_A) || ovf_d) frame_err_d = 1'b1;
      state_d = bus.en ? ST_WAIT_SOF : ST_IDLE;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      vsync_q      <= 1'b0;
      r_q          <= '0;
      ptr_q        <= '0;
      ovf_q        <= 1'b0;
      addr_in_q    <= '0;
      data_in_q    <= '0;
      regwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync_d;
      r_q          <= r_d;
      ptr_q        <= ptr_d;
      ovf_q        <= ovf_d;
      addr_in_q    <= addr_in_d;
      data_in_q    <= data_in_d;
      regwrite_q   <= regwrite_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.addr_in    = addr_in_q;
  assign bus.data_in    = data_in_q;
  assign bus.regwrite   = regwrite_q;
  assign bus.frame_done = frame_done_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture on a reduced 16x12 frame: the byte driver
// queues expected writes, a negedge monitor pops and compares them.
module tb_cam_pixel_capture;
  import cam_pixel_capture_pkg::*;

  localparam int AW    = 15;
  localparam int DW    = 12;
  localparam int IMG_W = 16;
  localparam int IMG_H = 12;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int LBYTES = 2 * IMG_W;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  always #5 pclk = ~pclk;

  cam_pixel_capture_if #(.AW(AW), .DW(DW)) bus ();

  cam_pixel_capture #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_chk = 0;
  int  n_err = 0;
  int  m_addr = 0;
  bit  m_active = 1'b0;
  int  exp_done = 0;
  int  done_cnt = 0;
  bit  exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  always @(negedge pclk) begin
    if (bus.frame_done === 1'b1) done_cnt++;
    if (bus.regwrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_addr", 32'(bus.addr_in), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.addr_in), 32'(mon_e.a));
        chk("wr_data", 32'(bus.data_in), 32'(mon_e.d));
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"},  32'(bus.addr_in),    32'd0);
    chk({tag, "_data"},  32'(bus.data_in),    32'd0);
    chk({tag, "_wr"},    32'(bus.regwrite),   32'd0);
    chk({tag, "_done"},  32'(bus.frame_done), 32'd0);
    chk({tag, "_err"},   32'(bus.frame_err),  32'd0);
  endtask

  // Ends the current frame with a vsync rise and opens the next one with en_v.
  task automatic vsync_seq(input bit en_v);
    bus.en    = en_v;
    bus.vsync = 1'b1;
    bus.href  = 1'b0;
    if (m_active) begin
      exp_done++;
      if (m_addr != NPIX) exp_err = 1'b1;
    end
    m_active = 1'b0;
    repeat (4) tick();
    bus.vsync = 1'b0;
    repeat (3) tick();
    m_addr   = 0;
    m_active = en_v;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_done_cnt"}, 32'(done_cnt),     32'(exp_done));
    chk({tag, "_err"},      32'(bus.frame_err), 32'(exp_err));
    chk({tag, "_sb_left"},  32'(exp_q.size()),  32'd0);
  endtask

  task automatic send_line(input int nbytes, input bit rnd, input int rst_byte);
    logic [7:0] b;
    logic [7:0] prev;
    prev = 8'h00;
    for (int i = 0; i < nbytes; i++) begin
      b = rnd ? 8'($urandom) : ((i % 2 == 1) ? 8'hBC : 8'h0A);
      bus.href    = 1'b1;
      bus.px_data = b;
      if (i == rst_byte) begin
        rst = 1'b0;
        tick();
        check_outputs_zero("midrst");
        chk("midrst_sb_left", 32'(exp_q.size()), 32'd0);
        rst      = 1'b1;
        m_active = 1'b0;
      end else begin
        if ((i % 2 == 1) && m_active) begin
          if (m_addr < NPIX) exp_q.push_back('{a: AW'(m_addr), d: {prev[3:0], b}});
          m_addr++;
        end
        tick();
      end
      prev = b;
    end
    bus.href    = 1'b0;
    bus.px_data = 8'h00;
    repeat (3) tick();
  endtask

  task automatic send_frame(input int nlines, input int nbytes, input bit rnd,
                            input int rst_line, input int rst_byte);
    for (int l = 0; l < nlines; l++)
      send_line(nbytes, rnd, (l == rst_line) ? rst_byte : -1);
  endtask

  initial begin
    bus.en      = 1'b0;
    bus.vsync   = 1'b0;
    bus.href    = 1'b0;
    bus.px_data = 8'h00;
    rst         = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    rst = 1'b1;
    repeat (2) tick();

    // Fixed-pattern full frame: every write must be 0xABC at ascending addresses.
    vsync_seq(1'b1);
    send_frame(IMG_H, LBYTES, 1'b0, -1, -1);
    vsync_seq(1'b0);
    check_frame("full");

    // Frame opened with en low: nothing written, no frame_done.
    send_frame(IMG_H, LBYTES, 1'b1, -1, -1);
    vsync_seq(1'b1);
    check_frame("disabled");

    // Odd-length lines and en dropped mid-frame: still a complete, error-free frame.
    for (int l = 0; l < IMG_H; l++) begin
      if (l == 5) bus.en = 1'b0;
      send_line(LBYTES + 1, 1'b1, -1);
    end
    vsync_seq(1'b1);
    check_frame("oddline");

    // Reset at pixel 50 aborts the frame silently.
    send_frame(IMG_H, LBYTES, 1'b1, 50 / IMG_W, 2 * (50 % IMG_W));
    vsync_seq(1'b1);
    check_frame("midrst");

    // Short frame, then a good frame: error sticks.
    send_frame(IMG_H - 2, LBYTES, 1'b1, -1, -1);
    vsync_seq(1'b1);
    check_frame("short");
    send_frame(IMG_H, LBYTES, 1'b1, -1, -1);
    vsync_seq(1'b1);
    check_frame("good_after_err");

    // Long frame: writes stop at NPIX-1, frame flagged.
    send_frame(IMG_H + 1, LBYTES, 1'b1, -1, -1);
    vsync_seq(1'b0);
    check_frame("long");

    repeat (4) tick();
    chk("final_sb_left", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
